// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle controller and its datapath:
// opcodes, funct codes, ALU operations, FSM state encodings and mux selects.
package mc_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // ALU operation select, shared with the datapath
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;

    // FSM state encodings (visible on state_o)
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEM_ADR = 4'd2;
    localparam logic [3:0] S_MEM_RD  = 4'd3;
    localparam logic [3:0] S_MEM_WB  = 4'd4;
    localparam logic [3:0] S_MEM_WR  = 4'd5;
    localparam logic [3:0] S_EXE_R   = 4'd6;
    localparam logic [3:0] S_R_WB    = 4'd7;
    localparam logic [3:0] S_EXE_ORI = 4'd8;
    localparam logic [3:0] S_ORI_WB  = 4'd9;
    localparam logic [3:0] S_BRANCH  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_LUI_WB  = 4'd12;
    localparam logic [3:0] S_TRAP    = 4'd13;

    // Datapath mux selects
    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_REG     = 1'b1;
    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
    localparam logic       EXT_ZERO     = 1'b0;
    localparam logic       EXT_SIGN     = 1'b1;
    localparam logic       DST_RT       = 1'b0;
    localparam logic       DST_RD       = 1'b1;
    localparam logic [1:0] WB_ALU       = 2'd0;
    localparam logic [1:0] WB_MDR       = 2'd1;
    localparam logic [1:0] WB_LUI       = 2'd2;
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // States that wait on memory and therefore run the latency counter
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and flags in, strobes and selects out.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       mem_wr;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic       reg_dst;
    logic [1:0] wb_sel;
    logic [1:0] pc_src;
    logic [3:0] state_o;
    logic       illegal;

    modport master (
        input  op, funct, zero,
        output pc_wr, ir_wr, reg_wr, mem_wr, alu_op, alu_src_a, alu_src_b,
               ext_op, reg_dst, wb_sel, pc_src, state_o, illegal
    );

    modport slave (
        output op, funct, zero,
        input  pc_wr, ir_wr, reg_wr, mem_wr, alu_op, alu_src_a, alu_src_b,
               ext_op, reg_dst, wb_sel, pc_src, state_o, illegal
    );
endinterface

// File: rtl/mc_wait_cnt.sv
// Memory latency counter: counts cycles spent in a memory-access state and
// flags the last one. Cleared by the controller on every state change.
module mc_wait_cnt #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);
    logic [3:0] cnt;

    // Count up while enabled; a clear (state change) restarts from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= 4'd0;
        else if (clr)
            cnt <= 4'd0;
        else if (en)
            cnt <= cnt + 4'd1;
    end

    assign done = en && (cnt == 4'(LAT - 1));
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the single-ALU CPU datapath.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (undecodable instructions
// trap instead of retiring as a NOP).
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    mc_ctrl_if.master  bus
);
    logic [3:0] state;
    logic [3:0] next_state;
    logic [3:0] bad_state;
    logic       wait_done;
    logic       pc_wr_raw, ir_wr_raw, reg_wr_raw, mem_wr_raw;
    logic [2:0] alu_op;
    logic       alu_src_a, ext_op, reg_dst;
    logic [1:0] alu_src_b, wb_sel, pc_src;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign bad_state   = S_TRAP;
    assign bus.illegal = (state == S_TRAP);
`else
    assign bad_state   = S_FETCH;
    assign bus.illegal = 1'b0;
`endif

    mc_wait_cnt #(.LAT(MEM_LAT)) u_wait (
        .clk   (clk),
        .reset (reset),
        .clr   (next_state != state),
        .en    (is_mem_state(state)),
        .done  (wait_done)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // Instruction sequencing; memory states hold until the counter is done
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:   if (wait_done) next_state = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: next_state = S_MEM_ADR;
                    OP_RTYPE:     next_state = (bus.funct == FN_ADDU || bus.funct == FN_SUBU)
                                               ? S_EXE_R : bad_state;
                    OP_ORI:       next_state = S_EXE_ORI;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_LUI:       next_state = S_LUI_WB;
                    default:      next_state = bad_state;
                endcase
            end
            S_MEM_ADR: next_state = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (wait_done) next_state = S_MEM_WB;
            S_MEM_WR:  if (wait_done) next_state = S_FETCH;
            S_EXE_R:   next_state = S_R_WB;
            S_EXE_ORI: next_state = S_ORI_WB;
            S_TRAP:    next_state = S_TRAP;
            default:   next_state = S_FETCH;
        endcase
    end

    // Per-state datapath controls; everything not listed stays zero
    always_comb begin
        pc_wr_raw  = 1'b0;
        ir_wr_raw  = 1'b0;
        reg_wr_raw = 1'b0;
        mem_wr_raw = 1'b0;
        alu_op     = ALU_ADD;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        ext_op     = EXT_ZERO;
        reg_dst    = DST_RT;
        wb_sel     = WB_ALU;
        pc_src     = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                ir_wr_raw = wait_done;
                pc_wr_raw = wait_done;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                ext_op    = EXT_SIGN;
            end
            S_MEM_ADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                ext_op    = EXT_SIGN;
            end
            S_MEM_WB: begin
                reg_wr_raw = 1'b1;
                wb_sel     = WB_MDR;
            end
            S_MEM_WR:  mem_wr_raw = 1'b1;
            S_EXE_R: begin
                alu_src_a = SRCA_REG;
                alu_op    = (bus.funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            end
            S_R_WB: begin
                reg_wr_raw = 1'b1;
                reg_dst    = DST_RD;
            end
            S_EXE_ORI: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OR;
            end
            S_ORI_WB:  reg_wr_raw = 1'b1;
            S_BRANCH: begin
                alu_src_a = SRCA_REG;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_wr_raw = bus.zero;
            end
            S_JUMP: begin
                pc_src    = PCSRC_JUMP;
                pc_wr_raw = 1'b1;
            end
            S_LUI_WB: begin
                reg_wr_raw = 1'b1;
                wb_sel     = WB_LUI;
            end
            default: ;
        endcase
    end

    assign bus.pc_wr     = pc_wr_raw  & ~reset;
    assign bus.ir_wr     = ir_wr_raw  & ~reset;
    assign bus.reg_wr    = reg_wr_raw & ~reset;
    assign bus.mem_wr    = mem_wr_raw & ~reset;
    assign bus.alu_op    = alu_op;
    assign bus.alu_src_a = alu_src_a;
    assign bus.alu_src_b = alu_src_b;
    assign bus.ext_op    = ext_op;
    assign bus.reg_dst   = reg_dst;
    assign bus.wb_sel    = wb_sel;
    assign bus.pc_src    = pc_src;
    assign bus.state_o   = state;
endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: three instances with MEM_LAT = 1, 3 and 2 share the
// same stimulus; a selector picks which instance is being observed.
// Honours MC_CTRL_ILLEGAL_TRAP_EN for the undecodable-opcode case.
module tb_mc_ctrl;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    int         sel = 0;

    int total = 0;
    int bad = 0;

    mc_ctrl_if if1();
    mc_ctrl_if if3();
    mc_ctrl_if if2();

    assign if1.op = op;  assign if1.funct = funct;  assign if1.zero = zero;
    assign if3.op = op;  assign if3.funct = funct;  assign if3.zero = zero;
    assign if2.op = op;  assign if2.funct = funct;  assign if2.zero = zero;

    mc_ctrl #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    mc_ctrl #(.MEM_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));
    mc_ctrl #(.MEM_LAT(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    always #5 clk = ~clk;

    logic [3:0] o_state;
    logic       o_pc_wr, o_ir_wr, o_reg_wr, o_mem_wr, o_reg_dst, o_illegal;
    logic [2:0] o_alu_op;
    logic [1:0] o_wb_sel, o_pc_src;

    // Route the selected instance onto the observation signals
    always_comb begin
        o_state = if1.state_o;   o_pc_wr = if1.pc_wr;   o_ir_wr = if1.ir_wr;
        o_reg_wr = if1.reg_wr;   o_mem_wr = if1.mem_wr; o_reg_dst = if1.reg_dst;
        o_illegal = if1.illegal; o_alu_op = if1.alu_op; o_wb_sel = if1.wb_sel;
        o_pc_src = if1.pc_src;
        if (sel == 1) begin
            o_state = if3.state_o;   o_pc_wr = if3.pc_wr;   o_ir_wr = if3.ir_wr;
            o_reg_wr = if3.reg_wr;   o_mem_wr = if3.mem_wr; o_reg_dst = if3.reg_dst;
            o_illegal = if3.illegal; o_alu_op = if3.alu_op; o_wb_sel = if3.wb_sel;
            o_pc_src = if3.pc_src;
        end else if (sel == 2) begin
            o_state = if2.state_o;   o_pc_wr = if2.pc_wr;   o_ir_wr = if2.ir_wr;
            o_reg_wr = if2.reg_wr;   o_mem_wr = if2.mem_wr; o_reg_dst = if2.reg_dst;
            o_illegal = if2.illegal; o_alu_op = if2.alu_op; o_wb_sel = if2.wb_sel;
            o_pc_src = if2.pc_src;
        end
    end

    // Per-instruction record filled by applyStimulus
    int         r_cycles, r_pc_wr, r_ir_wr, r_reg_wr, r_mem_wr, r_illegal;
    logic       r_first_ir_wr, r_first_pc_wr;
    int         st_cycles [14];
    logic [2:0] st_alu_op [14];
    logic [1:0] st_pc_src [14];
    logic [1:0] st_wb_sel [14];
    logic       st_reg_dst [14];
    logic       st_reg_wr [14];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Hold reset two cycles; returns at a falling edge with reset released
    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Run one instruction from the first FETCH cycle up to the next FETCH entry
    task automatic applyStimulus(input logic [5:0] op_i, input logic [5:0] funct_i,
                                 input logic zero_i);
        logic [3:0] prev;
        bit         fin;
        op = op_i;  funct = funct_i;  zero = zero_i;
        r_cycles = 0; r_pc_wr = 0; r_ir_wr = 0; r_reg_wr = 0; r_mem_wr = 0; r_illegal = 0;
        r_first_ir_wr = 1'b0; r_first_pc_wr = 1'b0;
        for (int i = 0; i < 14; i++) begin
            st_cycles[i] = 0; st_alu_op[i] = '0; st_pc_src[i] = '0;
            st_wb_sel[i] = '0; st_reg_dst[i] = 1'b0; st_reg_wr[i] = 1'b0;
        end
        fin = 1'b0;
        while (!fin) begin
            #1;
            if (r_cycles == 0) begin
                r_first_ir_wr = o_ir_wr;
                r_first_pc_wr = o_pc_wr;
            end
            r_pc_wr  += int'(o_pc_wr);
            r_ir_wr  += int'(o_ir_wr);
            r_reg_wr += int'(o_reg_wr);
            r_mem_wr += int'(o_mem_wr);
            r_illegal += int'(o_illegal);
            if (o_state < 4'd14) begin
                st_cycles[o_state]++;
                st_alu_op[o_state]  = o_alu_op;
                st_pc_src[o_state]  = o_pc_src;
                st_wb_sel[o_state]  = o_wb_sel;
                st_reg_dst[o_state] = o_reg_dst;
                st_reg_wr[o_state]  = st_reg_wr[o_state] | o_reg_wr;
            end
            r_cycles++;
            prev = o_state;
            @(negedge clk);
            if (o_state == S_FETCH && prev != S_FETCH)
                fin = 1'b1;
            else if (r_cycles >= 64) begin
                checkOutput("instr_timeout", 32'(r_cycles), 32'd0);
                fin = 1'b1;
            end
        end
    endtask

    initial begin
        // Reset asserted mid-instruction (sw in MEM_WR, MEM_LAT=2)
        sel = 2;
        op = OP_SW;
        doReset();
        for (int i = 0; i < 20; i++) begin
            if (o_state == S_MEM_WR) break;
            @(negedge clk);
        end
        checkOutput("reach_mem_wr", 32'(o_state), 32'(S_MEM_WR));
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_state", 32'(o_state), 32'd0);
        checkOutput("rst_mem_wr", 32'(o_mem_wr), 32'd0);
        // MEM_LAT=1 FETCH would strobe if reset did not mask it
        sel = 0;
        @(negedge clk);
        #1;
        checkOutput("rst_ir_wr", 32'(o_ir_wr), 32'd0);
        checkOutput("rst_pc_wr", 32'(o_pc_wr), 32'd0);

        // MEM_LAT=1 instruction mix
        doReset();
        applyStimulus(OP_RTYPE, FN_ADDU, 1'b0);
        checkOutput("first_ir_wr", 32'(r_first_ir_wr), 32'd1);
        checkOutput("first_pc_wr", 32'(r_first_pc_wr), 32'd1);
        checkOutput("addu_cycles", 32'(r_cycles), 32'd4);
        checkOutput("addu_alu_op", 32'(st_alu_op[6]), 32'd0);
        checkOutput("addu_reg_wr", 32'(st_reg_wr[7]), 32'd1);
        checkOutput("addu_reg_dst", 32'(st_reg_dst[7]), 32'd1);

        applyStimulus(OP_RTYPE, FN_SUBU, 1'b0);
        checkOutput("subu_cycles", 32'(r_cycles), 32'd4);
        checkOutput("subu_alu_op", 32'(st_alu_op[6]), 32'd1);
        checkOutput("subu_reg_wr", 32'(st_reg_wr[7]), 32'd1);

        applyStimulus(OP_ORI, 6'h00, 1'b0);
        checkOutput("ori_cycles", 32'(r_cycles), 32'd4);
        checkOutput("ori_alu_op", 32'(st_alu_op[8]), 32'd2);
        checkOutput("ori_reg_wr", 32'(st_reg_wr[9]), 32'd1);

        applyStimulus(OP_BEQ, 6'h00, 1'b1);
        checkOutput("beq_t_cycles", 32'(r_cycles), 32'd3);
        checkOutput("beq_t_pc_wr", 32'(r_pc_wr), 32'd2);
        checkOutput("beq_t_pc_src", 32'(st_pc_src[10]), 32'd1);
        checkOutput("beq_t_alu_op", 32'(st_alu_op[10]), 32'd1);

        applyStimulus(OP_BEQ, 6'h00, 1'b0);
        checkOutput("beq_nt_cycles", 32'(r_cycles), 32'd3);
        checkOutput("beq_nt_pc_wr", 32'(r_pc_wr), 32'd1);

        applyStimulus(OP_J, 6'h00, 1'b0);
        checkOutput("j_cycles", 32'(r_cycles), 32'd3);
        checkOutput("j_pc_wr", 32'(r_pc_wr), 32'd2);
        checkOutput("j_pc_src", 32'(st_pc_src[11]), 32'd2);

        applyStimulus(OP_LUI, 6'h00, 1'b0);
        checkOutput("lui_cycles", 32'(r_cycles), 32'd3);
        checkOutput("lui_wb_sel", 32'(st_wb_sel[12]), 32'd2);
        checkOutput("lui_reg_wr", 32'(r_reg_wr), 32'd1);

        applyStimulus(OP_RTYPE, 6'h20, 1'b0);
        checkOutput("badfn_cycles", 32'(r_cycles), 32'd2);
        checkOutput("badfn_reg_wr", 32'(r_reg_wr), 32'd0);

`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        applyStimulus(6'h3F, 6'h00, 1'b0);
        checkOutput("ill_cycles", 32'(r_cycles), 32'd2);
        checkOutput("ill_reg_wr", 32'(r_reg_wr), 32'd0);
        checkOutput("ill_mem_wr", 32'(r_mem_wr), 32'd0);
        checkOutput("ill_pc_wr", 32'(r_pc_wr), 32'd1);
        checkOutput("ill_flag", 32'(r_illegal), 32'd0);
`endif

        // lw with MEM_LAT=3
        sel = 1;
        doReset();
        applyStimulus(OP_LW, 6'h00, 1'b0);
        checkOutput("lw_cycles", 32'(r_cycles), 32'd9);
        checkOutput("lw_fetch_cyc", 32'(st_cycles[0]), 32'd3);
        checkOutput("lw_memrd_cyc", 32'(st_cycles[3]), 32'd3);
        checkOutput("lw_wb_sel", 32'(st_wb_sel[4]), 32'd1);
        checkOutput("lw_ir_wr", 32'(r_ir_wr), 32'd1);
        checkOutput("lw_reg_wr", 32'(r_reg_wr), 32'd1);

        // sw with MEM_LAT=2
        sel = 2;
        doReset();
        applyStimulus(OP_SW, 6'h00, 1'b0);
        checkOutput("sw_cycles", 32'(r_cycles), 32'd6);
        checkOutput("sw_mem_wr", 32'(r_mem_wr), 32'd2);
        checkOutput("sw_reg_wr", 32'(r_reg_wr), 32'd0);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        // Undecodable op traps and stays there until reset
        sel = 0;
        doReset();
        op = 6'h3F;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("trap_state", 32'(o_state), 32'(S_TRAP));
        checkOutput("trap_illegal", 32'(o_illegal), 32'd1);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("trap_held", 32'(o_illegal), 32'd1);
        checkOutput("trap_strobes",
                    32'({o_pc_wr, o_ir_wr, o_reg_wr, o_mem_wr}), 32'd0);
        doReset();
        #1;
        checkOutput("trap_cleared", 32'(o_illegal), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the single-ALU CPU datapath.
- Decodes the IR opcode and funct fields and sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the ALU operation select (0 add, 1 sub, 2 or), the datapath mux selects and all register/memory write strobes.
- Handles variable-latency memory via a per-state wait counter.

Parameters:
- MEM_LAT, 1, cycles spent in each memory-access state (FETCH, MEM_RD, MEM_WR); legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU result == 0, valid in the BRANCH state.
- pc_wr  out  1  PC write strobe, already qualified by zero for beq.
- ir_wr  out  1  IR write strobe.
- reg_wr  out  1  register file write strobe.
- mem_wr  out  1  data memory write strobe.
- alu_op  out  3  0 add, 1 sub, 2 or.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  0 = register B, 1 = const 4, 2 = extended imm, 3 = extended imm<<2.
- ext_op  out  1  0 = zero-extend, 1 = sign-extend.
- reg_dst  out  1  0 = rt, 1 = rd.
- wb_sel  out  2  0 = ALUOut, 1 = MDR, 2 = imm<<16.
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- state_o  out  4  current state encoding, for debug.
- illegal  out  1  see Optional Feature.

Behaviour:
- Decoded instructions:
  - R-type (op 000000): addu (funct 100001), subu (funct 100011).
  - ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010.
- State encodings: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXE_R=6, R_WB=7, EXE_ORI=8, ORI_WB=9, BRANCH=10, JUMP=11, LUI_WB=12, TRAP=13.
- Reset:
  - Asynchronous: state=FETCH, wait counter=0.
  - While reset is high, pc_wr, ir_wr, reg_wr and mem_wr are forced to 0.
  - Asserting reset mid-instruction abandons the instruction with no partial writes after the reset edge.
- Default output value in every state is 0 unless listed below.
- FETCH:
  - alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
  - Holds MEM_LAT cycles; ir_wr and pc_wr pulse only on the last cycle, then go to DECODE.
- DECODE:
  - Computes the branch target: alu_src_a=0, alu_src_b=3, ext_op=1, alu_op=0.
  - Next state by op: lw/sw -> MEM_ADR; R -> EXE_R; ori -> EXE_ORI; beq -> BRANCH; j -> JUMP; lui -> LUI_WB.
  - Any other op, or an R-type funct other than 100001/100011 -> FETCH (no writes).
- MEM_ADR: alu_src_a=1, alu_src_b=2, ext_op=1, alu_op=0; next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: holds MEM_LAT cycles, then MEM_WB.
- MEM_WB: reg_wr=1, reg_dst=0, wb_sel=1; next FETCH.
- MEM_WR: mem_wr=1 on every one of its MEM_LAT cycles; next FETCH.
- EXE_R: alu_src_a=1, alu_src_b=0; alu_op=0 for addu, 1 for subu; next R_WB.
- R_WB: reg_wr=1, reg_dst=1, wb_sel=0; next FETCH.
- EXE_ORI: alu_src_a=1, alu_src_b=2, ext_op=0, alu_op=2; next ORI_WB.
- ORI_WB: reg_wr=1, reg_dst=0, wb_sel=0; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1; pc_wr=zero (combinational); next FETCH.
- JUMP: pc_src=2, pc_wr=1; next FETCH.
- LUI_WB: reg_wr=1, reg_dst=0, wb_sel=2; next FETCH.
- Wait counter:
  - 4 bits; cleared on every state change.
  - Increments while in FETCH, MEM_RD or MEM_WR; leaves the state when counter == MEM_LAT-1.
  - With MEM_LAT=1 every state is exactly one cycle.
- Cycles per instruction (including FETCH), with L = MEM_LAT:
  - lw 3+2L, sw 2+2L, R/ori 3+L.
  - beq/j/lui 2+L.
  - illegal (without the macro) 1+L.
- op and funct are sampled from the IR, which is stable from DECODE until the next FETCH completes.

Optional Feature:
- Macro MC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An undecodable op/funct in DECODE goes to TRAP.
  - TRAP asserts illegal=1 with all strobes 0 and is held until reset.
- Undefined: illegal is tied to 0; undecodable instructions return to FETCH as a NOP and TRAP is unreachable.

Decomposition:
- Shared package mc_pkg holds:
  - opcode and funct constants;
  - ALU op constants (ALU_ADD=0, ALU_SUB=1, ALU_OR=2), also used by the datapath;
  - state encodings;
  - mux-select encodings.
- One natural sub-module, mc_wait_cnt: the latency counter with clear, enable and a done output.

Test Plan:
- Reset, MEM_LAT=1:
  - Assert reset mid-state -> state_o=0 and all strobes 0 immediately.
  - After release -> ir_wr=pc_wr=1 in the first cycle.
- addu, then subu (op 0, funct 21h/23h):
  - EXE_R alu_op=0 and 1 respectively.
  - R_WB reg_wr=1, reg_dst=1; 4 cycles each.
- lw with MEM_LAT=3:
  - FETCH 3 cycles, MEM_RD 3 cycles; MEM_WB wb_sel=1; 9 cycles total.
- sw, MEM_LAT=2: mem_wr high for exactly 2 cycles; reg_wr never asserted.
- beq:
  - zero=1 -> pc_wr=1, pc_src=1, alu_op=1.
  - zero=0 -> pc_wr=0; 3 cycles.
  - j -> pc_src=2, pc_wr=1.
- op=3Fh:
  - With the macro -> illegal=1, held until reset.
  - Without it -> back to FETCH after 2 cycles, no strobes.
